// File: rtl/seqdet_pkg.sv
// Shared definitions for the serial sequence detector slice.
//  - state_t    : serializer FSM state encoding (ST_IDLE=0, ST_SHIFT=1)
//  - DEF_WORD_W : default bits per parallel word
//  - DEF_FIFO_DEPTH : default input buffering in words
package seqdet_pkg;

  localparam int DEF_WORD_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bit_stream_serializer_if.sv
// Bus bundle for bit_stream_serializer.
//  Parallel side : in_data, in_valid (from producer), in_ready (to producer)
//  Serial side   : x_out, x_valid, word_done
//  Status        : busy, fifo_count, dbg_state (FSM state for checkers)
// Handshake: a word transfers on a rising edge where in_valid & in_ready are
//  both 1. in_ready depends on registered state only and never on in_valid,
//  so the producer may wait for in_ready before raising in_valid or hold
//  in_valid high with stable in_data until accepted.
interface bit_stream_serializer_if
  import seqdet_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);

  logic [WORD_W-1:0]                 in_data;
  logic                              in_valid;
  logic                              in_ready;
  logic                              x_out;
  logic                              x_valid;
  logic                              word_done;
  logic                              busy;
  logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count;
  state_t                            dbg_state;

  // Producer / observer side.
  modport master (
    output in_data, in_valid,
    input  in_ready, x_out, x_valid, word_done, busy, fifo_count, dbg_state
  );

  // The serializer itself.
  modport slave (
    input  in_data, in_valid,
    output in_ready, x_out, x_valid, word_done, busy, fifo_count, dbg_state
  );

endinterface

// File: rtl/bit_stream_serializer_fifo.sv
// sync_word_fifo: single-clock word FIFO, W bits x DEPTH entries.
//  push/wdata : write when push=1 and not full (a push while full is dropped)
//  pop/rdata  : rdata is the head entry; pop advances it when not empty
//  count      : entries held; full/empty decoded from count
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_word_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign count   = count_q;

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer: buffers parallel words in a small FIFO and shifts
// them out one bit per clock on x_out, qualified by x_valid. A word queued
// when the current one finishes is loaded on the same edge, so consecutive
// words form one gap-free stream.
//  clk, rst : clock, asynchronous active-high reset
//  bus      : bit_stream_serializer_if.slave (see interface for signal list)
// All serial-side outputs and in_ready are decoded from registers only.
module bit_stream_serializer
  import seqdet_pkg::*;
#(
  parameter int   WORD_W     = DEF_WORD_W,
  parameter int   FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  bit_stream_serializer_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int BW = $clog2(WORD_W);

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [BW-1:0]       cnt_q, cnt_d;
  logic                pop;
  logic [WORD_W-1:0]   fifo_rdata;
  logic [CW-1:0]       fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                shifting;
  logic                head;

  sync_word_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .pop   (pop),
    .wdata (bus.in_data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          cnt_d   = BW'(WORD_W-1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          // Last bit on the wire: chain straight into the next word if one
          // is waiting, otherwise fall back to idle.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            cnt_d   = BW'(WORD_W-1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          shift_d = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
          cnt_d   = cnt_q - BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign shifting       = (state_q == ST_SHIFT);
  assign head           = (MSB_FIRST != 0) ? shift_q[WORD_W-1] : shift_q[0];

  assign bus.in_ready   = !fifo_full;
  assign bus.x_valid    = shifting;
  assign bus.x_out      = shifting ? head : IDLE_BIT;
  assign bus.word_done  = shifting && (cnt_q == '0);
  assign bus.busy       = shifting || !fifo_empty;
  assign bus.fifo_count = fifo_count;
  assign bus.dbg_state  = state_q;

endmodule
